// File: rtl/sram_write_checker.sv
// SRAM write checker: snoops SRAM writes and compares each one against an
// expected-data memory. It also tracks which words of the output region were
// written, and sweeps for unwritten words on request.
module sram_write_checker #(
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned REGION_BASE    = 146944,
  parameter int unsigned REGION_DEPTH   = 115200,
  parameter int unsigned MAX_MISMATCHES = 10,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Finish,
  input  logic              Snoop_we_n,
  input  logic [ADDR_W-1:0] Snoop_address,
  input  logic [DATA_W-1:0] Snoop_write_data,
  output logic [ADDR_W-1:0] Exp_address,
  input  logic [DATA_W-1:0] Exp_data,
  output logic [CNT_W-1:0]  Mismatch_count,
  output logic [CNT_W-1:0]  Out_of_region_count,
  output logic [CNT_W-1:0]  Multi_write_count,
  output logic [CNT_W-1:0]  Unwritten_count,
  output logic              Error_valid,
  output logic [ADDR_W-1:0] Error_address,
  output logic [DATA_W-1:0] Error_data,
  output logic [DATA_W-1:0] Error_expected,
  output logic              Halt,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned IDX_W = (REGION_DEPTH > 1) ? $clog2(REGION_DEPTH) : 1;
  // One extra bit so that REGION_BASE+REGION_DEPTH can reach 2^ADDR_W.
  localparam logic [ADDR_W:0]  RegionLo = (ADDR_W+1)'(REGION_BASE);
  localparam logic [ADDR_W:0]  RegionHi = (ADDR_W+1)'(REGION_BASE + REGION_DEPTH);
  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(REGION_DEPTH - 1);
  localparam logic [CNT_W-1:0] MaxMm    = CNT_W'(MAX_MISMATCHES);

  typedef enum logic [1:0] {S_CLEAR, S_MONITOR, S_SWEEP, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [REGION_DEPTH-1:0] bitmap_q, bitmap_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]       s1_addr_q, s1_addr_d;
  logic [DATA_W-1:0]       s1_data_q, s1_data_d;
  logic [CNT_W-1:0]        mm_q, mm_d, oor_q, oor_d, multi_q, multi_d, unw_q, unw_d;
  logic                    err_valid_q, err_valid_d;
  logic [ADDR_W-1:0]       err_addr_q, err_addr_d;
  logic [DATA_W-1:0]       err_data_q, err_data_d, err_exp_q, err_exp_d;
  logic                    halt_q, halt_d;

  logic [ADDR_W:0]  addr_ext;
  logic             in_region;
  logic [IDX_W-1:0] snoop_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // The expected-data memory is read in lock-step with the snooped write.
  assign Exp_address = Snoop_address;

  // Decode whether the snooped address falls in the output region.
  always_comb begin
    addr_ext  = {1'b0, Snoop_address};
    in_region = (addr_ext >= RegionLo) && (addr_ext < RegionHi);
    snoop_idx = IDX_W'(addr_ext - RegionLo);
  end

  // Next-state: FSM, stage-0 bitmap bookkeeping and stage-1 compare.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bitmap_d    = bitmap_q;
    s1_valid_d  = 1'b0;
    s1_addr_d   = s1_addr_q;
    s1_data_d   = s1_data_q;
    mm_d        = mm_q;
    oor_d       = oor_q;
    multi_d     = multi_q;
    unw_d       = unw_q;
    err_valid_d = 1'b0;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    err_exp_d   = err_exp_q;
    halt_d      = halt_q;

    // Stage 1 runs in every state so a write in flight at Finish still completes.
    if (s1_valid_q && (Exp_data != s1_data_q)) begin
      err_valid_d = 1'b1;
      err_addr_d  = s1_addr_q;
      err_data_d  = s1_data_q;
      err_exp_d   = Exp_data;
      mm_d        = sat_inc(mm_q);
      if (mm_d >= MaxMm) halt_d = 1'b1;
    end

    case (state_q)
      S_CLEAR: begin
        bitmap_d[idx_q] = 1'b0;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = S_MONITOR;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_MONITOR: begin
        if (!Snoop_we_n) begin
          s1_valid_d = 1'b1;
          s1_addr_d  = Snoop_address;
          s1_data_d  = Snoop_write_data;
          if (in_region) begin
            if (bitmap_q[snoop_idx]) multi_d = sat_inc(multi_q);
            bitmap_d[snoop_idx] = 1'b1;
          end else begin
            oor_d = sat_inc(oor_q);
          end
        end
        if (Finish) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (!bitmap_q[idx_q]) unw_d = sat_inc(unw_q);
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase

    // Start overrides everything else decided this cycle.
    if (Start) begin
      state_d     = S_CLEAR;
      idx_d       = '0;
      bitmap_d    = bitmap_q;
      s1_valid_d  = 1'b0;
      mm_d        = '0;
      oor_d       = '0;
      multi_d     = '0;
      unw_d       = '0;
      err_valid_d = 1'b0;
      err_addr_d  = err_addr_q;
      err_data_d  = err_data_q;
      err_exp_d   = err_exp_q;
      halt_d      = 1'b0;
    end
  end

  // Control and statistics registers with synchronous reset.
  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      state_q     <= S_CLEAR;
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      mm_q        <= '0;
      oor_q       <= '0;
      multi_q     <= '0;
      unw_q       <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      err_exp_q   <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      mm_q        <= mm_d;
      oor_q       <= oor_d;
      multi_q     <= multi_d;
      unw_q       <= unw_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      err_exp_q   <= err_exp_d;
      halt_q      <= halt_d;
    end
  end

  // Datapath registers; the bitmap is cleared by S_CLEAR rather than by reset.
  always_ff @(posedge Clock_50) begin
    bitmap_q  <= bitmap_d;
    s1_addr_q <= s1_addr_d;
    s1_data_q <= s1_data_d;
  end

  // Outputs straight from state and registers.
  always_comb begin
    Mismatch_count      = mm_q;
    Out_of_region_count = oor_q;
    Multi_write_count   = multi_q;
    Unwritten_count     = unw_q;
    Error_valid         = err_valid_q;
    Error_address       = err_addr_q;
    Error_data          = err_data_q;
    Error_expected      = err_exp_q;
    Halt                = halt_q;
    Busy                = (state_q == S_CLEAR) || (state_q == S_SWEEP);
    Done                = (state_q == S_DONE);
  end

endmodule
